// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq
//   Sequencing stage that sits directly in front of the combinational FPU.
//   An F-extension instruction and its operand values are accepted over a
//   valid/ready handshake, funct5 is decoded into the FPU op code, and the
//   operands/op code are held on the FPU inputs for an op-dependent number of
//   cycles, so the FPU becomes a multicycle path. The FPU result is captured
//   and offered to writeback with rd over a second valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   instruction + operand handshake
//   instruction           raw 32-bit instruction
//   rs1_val, rs2_val      register operand values
//   fpu_in1, fpu_in2      operands to the FPU (stable while executing)
//   fpu_op                op code to the FPU, 6'h3F when not executing
//   fpu_out               result from the FPU
//   out_valid / out_ready result handshake
//   out_rd, out_data      destination register and captured result
//   out_illegal           instruction was not a supported FPU op

module fpu_issue_seq #(
    parameter int BUS_WIDTH = 32,
    parameter int LAT_ADD   = 1,
    parameter int LAT_MUL   = 2,
    parameter int LAT_DIV   = 8,
    parameter int LAT_SQRT  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instruction,
    input  logic [BUS_WIDTH-1:0] rs1_val,
    input  logic [BUS_WIDTH-1:0] rs2_val,
    output logic [BUS_WIDTH-1:0] fpu_in1,
    output logic [BUS_WIDTH-1:0] fpu_in2,
    output logic [5:0]           fpu_op,
    input  logic [BUS_WIDTH-1:0] fpu_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_rd,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 out_illegal
);

    localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LAT_DS  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
    localparam int LAT_MAX = (LAT_AM > LAT_DS) ? LAT_AM : LAT_DS;
    // Counter only has to hold LAT_MAX-1; keep at least one bit.
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [5:0] OP_NONE = 6'h3F;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [BUS_WIDTH-1:0] in1_q;
    logic [BUS_WIDTH-1:0] in2_q;
    logic [5:0]           op_q;

    logic                 dec_legal;
    logic [5:0]           dec_op;
    logic [CNT_W-1:0]     dec_cnt;
    logic                 accept;

    // Decode of the incoming instruction: op code and initial hold count.
    // fsqrt.s is only legal with a zero rs2 field.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_NONE;
        dec_cnt   = '0;
        if (instruction[6:0] == 7'b1010011 && instruction[26:25] == 2'b00) begin
            case (instruction[31:27])
                5'b00000: begin
                    dec_legal = 1'b1;
                    dec_op    = 6'd0;
                    dec_cnt   = CNT_W'(LAT_ADD - 1);
                end
                5'b00001: begin
                    dec_legal = 1'b1;
                    dec_op    = 6'd1;
                    dec_cnt   = CNT_W'(LAT_ADD - 1);
                end
                5'b00010: begin
                    dec_legal = 1'b1;
                    dec_op    = 6'd2;
                    dec_cnt   = CNT_W'(LAT_MUL - 1);
                end
                5'b00011: begin
                    dec_legal = 1'b1;
                    dec_op    = 6'd3;
                    dec_cnt   = CNT_W'(LAT_DIV - 1);
                end
                5'b01011: begin
                    if (instruction[24:20] == 5'd0) begin
                        dec_legal = 1'b1;
                        dec_op    = 6'd4;
                        dec_cnt   = CNT_W'(LAT_SQRT - 1);
                    end
                end
                default: begin
                    dec_legal = 1'b0;
                end
            endcase
        end
    end

    // Next state and handshake/FPU control outputs. The FPU only sees a
    // real op code during EXEC; everywhere else it gets the idle code.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        fpu_op     = OP_NONE;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = dec_legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                fpu_op = op_q;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath. Operands are latched only on accept, so
    // they stay put on the FPU inputs for the whole EXEC period and beyond.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= OP_NONE;
            out_rd      <= '0;
            out_data    <= '0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                in1_q  <= rs1_val;
                in2_q  <= rs2_val;
                op_q   <= dec_op;
                out_rd <= instruction[11:7];
                cnt    <= dec_cnt;
                if (!dec_legal) begin
                    out_illegal <= 1'b1;
                    out_data    <= '0;
                end
            end else if (state == EXEC) begin
                if (cnt == '0) begin
                    out_data    <= fpu_out;
                    out_illegal <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign fpu_in1 = in1_q;
    assign fpu_in2 = in2_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// tb_fpu_issue_seq
//   Directed bench for fpu_issue_seq. Each issued instruction pushes its
//   hand-computed expected response onto a scoreboard queue; an independent
//   monitor watches the FPU-side and writeback-side outputs and checks them
//   against the head of that queue.

module tb_fpu_issue_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] fpu_in1;
    logic [31:0] fpu_in2;
    logic [5:0]  fpu_op;
    logic [31:0] fpu_out;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_illegal;

    logic [31:0] fpu_res;
    int          cycle_cnt;
    int          checks;
    int          passes;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        int          exec_cycles;
        int          valid_lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fpu_issue_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .fpu_in1     (fpu_in1),
        .fpu_in2     (fpu_in2),
        .fpu_op      (fpu_op),
        .fpu_out     (fpu_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_data    (out_data),
        .out_illegal (out_illegal)
    );

    // FPU stand-in: returns the expected result while an op is presented,
    // and a poison value otherwise so a mistimed capture is visible.
    assign fpu_out = (fpu_op == 6'h3F) ? 32'hDEAD_BEEF : fpu_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        checks++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cycle_cnt);
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res,
                                 input logic [4:0] rd, input logic [31:0] data,
                                 input logic ill, input logic [5:0] op,
                                 input int lat, output int acc);
        exp_t e;
        int   n;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            reportFail("accept_timeout", "in_ready=0, required 1 within 200 cycles");
        end else begin
            instruction = instr;
            rs1_val     = a;
            rs2_val     = b;
            fpu_res     = res;
            in_valid    = 1'b1;
            acc         = cycle_cnt;
            e.a           = a;
            e.b           = b;
            e.op          = op;
            e.rd          = rd;
            e.data        = data;
            e.ill         = ill;
            e.exec_cycles = ill ? 0 : lat;
            e.valid_lat   = ill ? 1 : lat + 1;
            e.acc         = acc;
            sb.push_back(e);
            @(negedge clk);
            in_valid    = 1'b0;
            instruction = 32'hFFFF_FFFF;
            rs1_val     = 32'hA5A5_A5A5;
            rs2_val     = 32'h5A5A_5A5A;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            reportFail("drain_timeout", "scoreboard not empty after 300 cycles");
            sb.delete();
        end
    endtask

    // Monitor: checks FPU-side signals during execution and the writeback
    // response whenever out_valid is up, including latency and hold count.
    initial begin
        int   exec_seen;
        logic prev_valid;
        exp_t e;
        exec_seen  = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                exec_seen  = 0;
                prev_valid = 1'b0;
            end else begin
                if (fpu_op !== 6'h3F) begin
                    if (sb.size() == 0) begin
                        reportFail("exec_unexpected", $sformatf("fpu_op=%h with no op pending, required 3f", fpu_op));
                    end else begin
                        e = sb[0];
                        checkOutput("exec_fpu_op", 32'(fpu_op), 32'(e.op));
                        checkOutput("exec_fpu_in1", fpu_in1, e.a);
                        checkOutput("exec_fpu_in2", fpu_in2, e.b);
                        checkOutput("exec_in_ready", 32'(in_ready), 32'd0);
                    end
                    exec_seen++;
                end
                if (out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        reportFail("unexpected_valid", "out_valid=1, required 0");
                    end else begin
                        e = sb[0];
                        if (!prev_valid) begin
                            checkOutput("valid_latency", 32'(cycle_cnt - e.acc), 32'(e.valid_lat));
                            checkOutput("exec_cycles", 32'(exec_seen), 32'(e.exec_cycles));
                            exec_seen = 0;
                        end
                        checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
                        checkOutput("out_data", out_data, e.data);
                        checkOutput("out_illegal", 32'(out_illegal), 32'(e.ill));
                        checkOutput("done_fpu_op", 32'(fpu_op), 32'h3F);
                        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
                        if (out_ready === 1'b1) begin
                            void'(sb.pop_front());
                        end
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int acc_a;
        int acc_b;
        int n;
        cycle_cnt   = 0;
        checks      = 0;
        passes      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = 32'h0;
        rs1_val     = 32'h0;
        rs2_val     = 32'h0;
        fpu_res     = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_fpu_op", 32'(fpu_op), 32'h3F);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
        checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
        checkOutput("rst_fpu_in1", fpu_in1, 32'd0);
        checkOutput("rst_fpu_in2", fpu_in2, 32'd0);
        rst_n = 1'b1;

        // fadd.s f1,f2,f3: 1.0 + 1.0
        applyStimulus(32'h003170d3, 32'h3f800000, 32'h3f800000, 32'h40000000,
                      5'd1, 32'h40000000, 1'b0, 6'd0, 1, acc_a);
        waitDrain();

        // fdiv.s f30,f16,f15: 3.0 / 1.0
        applyStimulus(32'h18f87f53, 32'h40400000, 32'h3f800000, 32'h40400000,
                      5'd30, 32'h40400000, 1'b0, 6'd3, 8, acc_a);
        waitDrain();

        // fsqrt.s f23,f3: sqrt(4.0), rs2 value ignored by the FPU
        applyStimulus(32'h5801fbd3, 32'h40800000, 32'h12345678, 32'h40000000,
                      5'd23, 32'h40000000, 1'b0, 6'd4, 8, acc_a);
        waitDrain();

        // fsqrt.s with nonzero rs2 field is illegal
        applyStimulus(32'h5821fbd3, 32'h40800000, 32'h12345678, 32'h40000000,
                      5'd23, 32'h0, 1'b1, 6'h3F, 0, acc_a);
        waitDrain();

        // fmt=01 (double) is illegal
        applyStimulus(32'h023170d3, 32'h3f800000, 32'h3f800000, 32'h40000000,
                      5'd1, 32'h0, 1'b1, 6'h3F, 0, acc_a);
        waitDrain();

        // fmul.s f21,f7,f9: 2.0 * 3.0 under writeback backpressure
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(32'h1093fad3, 32'h40000000, 32'h40400000, 32'h40c00000,
                      5'd21, 32'h40c00000, 1'b0, 6'd2, 2, acc_a);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            reportFail("bp_valid_timeout", "out_valid=0, required 1 within 50 cycles");
        end
        repeat (4) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("bp_after_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_after_out_valid", 32'(out_valid), 32'd0);
        waitDrain();

        // Integer op is illegal; fsub.s f11,f20,f13 follows back-to-back
        applyStimulus(32'h003100b3, 32'h11111111, 32'h22222222, 32'h33333333,
                      5'd1, 32'h0, 1'b1, 6'h3F, 0, acc_a);
        applyStimulus(32'h08da75d3, 32'h40000000, 32'h3f800000, 32'h3f800000,
                      5'd11, 32'h3f800000, 1'b0, 6'd1, 1, acc_b);
        checkOutput("b2b_accept_gap", 32'(acc_b - acc_a), 32'd2);
        waitDrain();

        // Reset during the third EXEC cycle of fdiv.s discards the op
        applyStimulus(32'h18f87f53, 32'h40400000, 32'h3f800000, 32'h40400000,
                      5'd30, 32'h40400000, 1'b0, 6'd3, 8, acc_a);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_fpu_op", 32'(fpu_op), 32'h3F);
        checkOutput("mid_rst_fpu_in1", fpu_in1, 32'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checkOutput("post_rst_no_valid", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
